// File: rtl/instruction_memory_wide.sv
// Wide synchronous-read instruction memory: FETCH_WIDTH lanes per fetch,
// valid/ready request/response, load port, NOP fill and sticky OOB flag.
module instruction_memory_wide #(
  parameter int ADDR_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int FETCH_WIDTH = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic flush,
  input  logic req_valid,
  output logic req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_pc,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] resp_inst,
  output logic [FETCH_WIDTH-1:0] resp_lane_valid,
  output logic oob_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [INST_WIDTH-1:0] imem [DEPTH];

  logic accept;
  logic load_ok;
  logic pc_oob;
  logic [PW-1:0] lane_addr [FETCH_WIDTH];
  logic [FETCH_WIDTH*INST_WIDTH-1:0] lane_inst;
  logic [FETCH_WIDTH-1:0] lane_ok;

  assign req_ready = !load_en && !flush &&
                     (!resp_valid || resp_ready);
  assign accept = req_valid && req_ready;
  assign load_ok = {1'b0, load_addr} < DEPTH_P;
  assign pc_oob = {1'b0, req_pc} >= DEPTH_P;

  // Lane addresses use one extra bit so pc+k never wraps into range.
  always_comb begin
    lane_inst = {FETCH_WIDTH{NOP_INST}};
    lane_ok = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_addr[k] = {1'b0, req_pc} + PW'(k);
      if (lane_addr[k] < DEPTH_P) begin
        lane_ok[k] = 1'b1;
        lane_inst[k*INST_WIDTH +: INST_WIDTH] =
          imem[lane_addr[k][IW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && load_ok)
      imem[load_addr[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_pc <= '0;
      resp_inst <= {FETCH_WIDTH{NOP_INST}};
      resp_lane_valid <= '0;
      oob_error <= 1'b0;
    end else begin
      if (flush) begin
        resp_valid <= 1'b0;
      end else if (accept) begin
        resp_valid <= 1'b1;
        resp_pc <= req_pc;
        resp_inst <= lane_inst;
        resp_lane_valid <= lane_ok;
        if (pc_oob)
          oob_error <= 1'b1;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
